// File: rtl/hd_sched.sv
// Two-requester round-robin scheduler sharing one Hamming(7,4) correct-and-combine unit.
// Each request is decoded word by word over two cycles, then held until downstream accepts.
module hd_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_cnt,
    input  logic       in_valid_a,
    input  logic       in_valid_b,
    output logic       in_ready_a,
    output logic       in_ready_b,
    input  logic [6:0] code_word1_a,
    input  logic [6:0] code_word2_a,
    input  logic [6:0] code_word1_b,
    input  logic [6:0] code_word2_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_n,
    output logic       out_id,
    output logic [1:0] out_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StDec1, StDec2, StOut} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cw1_q, cw1_d;
    logic [6:0]  cw2_q, cw2_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [3:0]  c1_q, c1_d;
    logic        eb1_q, eb1_d;
    logic        err1_q, err1_d;
    logic [5:0]  out_n_q, out_n_d;
    logic        out_id_q, out_id_d;
    logic [1:0]  out_err_q, out_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [6:0]  dec_cw;
    logic [2:0]  syn;
    logic [2:0]  pos;
    logic        dec_eb;
    logic [3:0]  dec_c;
    logic        dec_nz;
    logic [5:0]  c1_x, c2_x, combined;
    logic        idle, inc;

    // last_q = 1 means B was granted most recently, so A wins the next tie.
    assign idle       = (state_q == StIdle);
    assign in_ready_a = !rst && idle && in_valid_a && (!in_valid_b || last_q);
    assign in_ready_b = !rst && idle && in_valid_b && (!in_valid_a || !last_q);

    always_comb begin
        dec_cw = (state_q == StDec2) ? cw2_q : cw1_q;
        syn    = {dec_cw[6] ^ dec_cw[3] ^ dec_cw[2] ^ dec_cw[1],
                  dec_cw[5] ^ dec_cw[3] ^ dec_cw[2] ^ dec_cw[0],
                  dec_cw[4] ^ dec_cw[3] ^ dec_cw[1] ^ dec_cw[0]};
        case (syn)
            3'b110:  pos = 3'd2;
            3'b101:  pos = 3'd1;
            3'b011:  pos = 3'd0;
            3'b111:  pos = 3'd3;
            3'b001:  pos = 3'd4;
            3'b010:  pos = 3'd5;
            default: pos = 3'd6;
        endcase
        dec_eb = dec_cw[pos];
        dec_c  = dec_cw[3:0];
        if (pos < 3'd4) begin
            dec_c[pos[1:0]] = ~dec_c[pos[1:0]];
        end
        dec_nz = |syn;
    end

    // Both operands fit in 6 bits after doubling, so no overflow handling is needed.
    always_comb begin
        c1_x = {{2{c1_q[3]}}, c1_q};
        c2_x = {{2{dec_c[3]}}, dec_c};
        unique case ({eb1_q, dec_eb})
            2'b00:   combined = {c1_x[4:0], 1'b0} + c2_x;
            2'b01:   combined = {c1_x[4:0], 1'b0} - c2_x;
            2'b10:   combined = c1_x - {c2_x[4:0], 1'b0};
            default: combined = c1_x + {c2_x[4:0], 1'b0};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cw1_d     = cw1_q;
        cw2_d     = cw2_q;
        id_d      = id_q;
        last_d    = last_q;
        c1_d      = c1_q;
        eb1_d     = eb1_q;
        err1_d    = err1_q;
        out_n_d   = out_n_q;
        out_id_d  = out_id_q;
        out_err_d = out_err_q;
        inc       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_ready_a || in_ready_b) begin
                    cw1_d   = in_ready_b ? code_word1_b : code_word1_a;
                    cw2_d   = in_ready_b ? code_word2_b : code_word2_a;
                    id_d    = in_ready_b;
                    last_d  = in_ready_b;
                    state_d = StDec1;
                end
            end
            StDec1: begin
                c1_d    = dec_c;
                eb1_d   = dec_eb;
                err1_d  = dec_nz;
                inc     = dec_nz;
                state_d = StDec2;
            end
            StDec2: begin
                out_n_d   = combined;
                out_id_d  = id_q;
                out_err_d = {err1_q, dec_nz};
                inc       = dec_nz;
                state_d   = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = 8'd0;
        end else if (inc && err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cw1_q     <= 7'd0;
            cw2_q     <= 7'd0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            c1_q      <= 4'd0;
            eb1_q     <= 1'b0;
            err1_q    <= 1'b0;
            out_n_q   <= 6'd0;
            out_id_q  <= 1'b0;
            out_err_q <= 2'd0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cw1_q     <= cw1_d;
            cw2_q     <= cw2_d;
            id_q      <= id_d;
            last_q    <= last_d;
            c1_q      <= c1_d;
            eb1_q     <= eb1_d;
            err1_q    <= err1_d;
            out_n_q   <= out_n_d;
            out_id_q  <= out_id_d;
            out_err_q <= out_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = (state_q == StOut);
    assign out_n     = out_n_q;
    assign out_id    = out_id_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hd_sched.sv
// Bench for hd_sched: request-level reference model checked every cycle, plus directed cases.
module tb_hd_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] code_word1_a = 7'd0;
    logic [6:0] code_word2_a = 7'd0;
    logic [6:0] code_word1_b = 7'd0;
    logic [6:0] code_word2_b = 7'd0;
    logic       in_ready_a, in_ready_b, out_valid, out_id;
    logic [5:0] out_n;
    logic [1:0] out_err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad = 0;

    hd_sched dut (
        .clk          (clk),
        .rst          (rst),
        .clr_cnt      (clr_cnt),
        .in_valid_a   (in_valid_a),
        .in_valid_b   (in_valid_b),
        .in_ready_a   (in_ready_a),
        .in_ready_b   (in_ready_b),
        .code_word1_a (code_word1_a),
        .code_word2_a (code_word2_a),
        .code_word1_b (code_word1_b),
        .code_word2_b (code_word2_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_n        (out_n),
        .out_id       (out_id),
        .out_err      (out_err),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act),
                     $signed(exp), $time);
        end
    endtask

    // Reference model: one in-flight request, tracked by edges since its acceptance.
    bit         m_busy = 1'b0;
    int         m_age = 0;
    bit         m_last = 1'b1;
    int         m_cnt = 0;
    int         m_n = 0;
    bit         m_id = 1'b0;
    bit   [1:0] m_err = 2'b00;
    bit         m_rid = 1'b0;
    logic [6:0] m_w1 = 7'd0;
    logic [6:0] m_w2 = 7'd0;

    function automatic void decode(input logic [6:0] w, output int c, output bit eb,
                                   output bit nz);
        bit [2:0] s;
        int       pos;
        int       d;
        s[2] = w[6] ^ w[3] ^ w[2] ^ w[1];
        s[1] = w[5] ^ w[3] ^ w[2] ^ w[0];
        s[0] = w[4] ^ w[3] ^ w[1] ^ w[0];
        case (s)
            3'b110:  pos = 2;
            3'b101:  pos = 1;
            3'b011:  pos = 0;
            3'b111:  pos = 3;
            3'b001:  pos = 4;
            3'b010:  pos = 5;
            default: pos = 6;
        endcase
        eb = w[pos];
        d  = int'(w[3:0]);
        if (pos < 4) d = d ^ (1 << pos);
        c  = (d >= 8) ? d - 16 : d;
        nz = (s != 3'b000);
    endfunction

    function automatic int combine(input int c1, input bit eb1, input int c2, input bit eb2);
        case ({eb1, eb2})
            2'b00:   return 2 * c1 + c2;
            2'b01:   return 2 * c1 - c2;
            2'b10:   return c1 - 2 * c2;
            default: return c1 + 2 * c2;
        endcase
    endfunction

    function automatic bit exp_ra();
        return !rst && !m_busy && in_valid_a && (!in_valid_b || m_last);
    endfunction

    function automatic bit exp_rb();
        return !rst && !m_busy && in_valid_b && (!in_valid_a || !m_last);
    endfunction

    always @(posedge clk) begin : model
        int c1, c2;
        bit e1, e2, n1, n2, inc;
        inc = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1; m_cnt = 0;
            m_n = 0; m_id = 1'b0; m_err = 2'b00;
        end else begin
            if (m_busy) begin
                if (m_age == 0) begin
                    decode(m_w1, c1, e1, n1);
                    inc = n1;
                end else if (m_age == 1) begin
                    decode(m_w1, c1, e1, n1);
                    decode(m_w2, c2, e2, n2);
                    inc   = n2;
                    m_n   = combine(c1, e1, c2, e2);
                    m_id  = m_rid;
                    m_err = {n1, n2};
                end else if (out_ready) begin
                    m_busy = 1'b0;
                end
                m_age++;
            end else if (exp_ra() || exp_rb()) begin
                m_rid  = exp_rb();
                m_w1   = m_rid ? code_word1_b : code_word1_a;
                m_w2   = m_rid ? code_word2_b : code_word2_a;
                m_last = m_rid;
                m_busy = 1'b1;
                m_age  = 0;
            end
            if (clr_cnt) m_cnt = 0;
            else if (inc && m_cnt < 255) m_cnt++;
        end
    end

    always @(negedge clk) begin
        check("in_ready_a", 32'(in_ready_a), 32'(exp_ra()));
        check("in_ready_b", 32'(in_ready_b), 32'(exp_rb()));
        check("out_valid", 32'(out_valid), 32'(m_busy && m_age >= 2));
        check("out_n", $signed(out_n), m_n);
        check("out_id", 32'(out_id), 32'(m_id));
        check("out_err", 32'(out_err), 32'(m_err));
        check("err_cnt", 32'(err_cnt), m_cnt);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input bit id, input string name);
        int n = 0;
        #1;
        while (!(id ? in_ready_b : in_ready_a) && n < 20) begin
            tick();
            #1;
            n++;
        end
        check(name, 32'(n < 20), 32'd1);
    endtask

    task automatic send(input bit id, input logic [6:0] w1, input logic [6:0] w2,
                        input int exp_n, input logic [1:0] exp_err, input int hold);
        in_valid_a = !id;
        in_valid_b = id;
        code_word1_a = w1; code_word2_a = w2;
        code_word1_b = w1; code_word2_b = w2;
        out_ready = 1'b0;
        wait_ready(id, "grant wait");
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        code_word1_a = 7'($urandom); code_word2_a = 7'($urandom);
        code_word1_b = 7'($urandom); code_word2_b = 7'($urandom);
        check("valid in dec1", 32'(out_valid), 32'd0);
        tick();
        check("valid in dec2", 32'(out_valid), 32'd0);
        tick();
        check("valid at T+3", 32'(out_valid), 32'd1);
        check("direct out_n", $signed(out_n), exp_n);
        check("direct out_id", 32'(out_id), 32'(id));
        check("direct out_err", 32'(out_err), 32'(exp_err));
        repeat (hold) begin
            tick();
            check("held out_n", $signed(out_n), exp_n);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid after accept", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int ids[4];
        int n;
        tick();
        tick();
        rst = 1'b0;
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);

        send(1'b0, 7'b1100011, 7'b0110001, 1, 2'b00, 2);
        check("clean err_cnt", 32'(err_cnt), 32'd0);
        send(1'b1, 7'b1100011, 7'b0110101, 5, 2'b01, 0);
        check("single err_cnt", 32'(err_cnt), 32'd1);
        send(1'b0, 7'b1111000, 7'b0000111, -22, 2'b00, 1);
        check("negative err_cnt", 32'(err_cnt), 32'd1);

        // Reset while a request sits in DEC2; A was granted last before this.
        in_valid_a = 1'b1;
        code_word1_a = 7'b1100011; code_word2_a = 7'b1100011;
        wait_ready(1'b0, "grant before reset");
        tick();
        in_valid_a = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (4) begin
            #1;
            check("no result after reset", 32'(out_valid), 32'd0);
            tick();
        end
        check("err_cnt after reset", 32'(err_cnt), 32'd0);
        check("out_n after reset", 32'(out_n), 32'd0);
        in_valid_a = 1'b1;
        in_valid_b = 1'b1;
        #1;
        check("tie goes to A", 32'(in_ready_a), 32'd1);
        check("tie B held", 32'(in_ready_b), 32'd0);

        // Both requesters stay valid while each result is back-pressured for 5 cycles.
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            check("fair wait", 32'(n < 10), 32'd1);
            ids[i] = int'(out_id);
            repeat (5) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        for (int i = 0; i < 4; i++) check("fair order", ids[i], i % 2);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        // Both words carry a bit0 flip (syndrome 011).
        in_valid_a = 1'b1;
        code_word1_a = 7'b1100010; code_word2_a = 7'b1100010;
        repeat (540) tick();
        check("saturated", 32'(err_cnt), 32'd255);
        in_valid_a = 1'b0;
        repeat (6) tick();
        check("still saturated", 32'(err_cnt), 32'd255);

        in_valid_a = 1'b1;
        wait_ready(1'b0, "grant before clear");
        tick();
        in_valid_a = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clear beats inc", 32'(err_cnt), 32'd0);
        tick();
        check("count after clear", 32'(err_cnt), 32'd1);
        repeat (4) tick();

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            clr_cnt      = ($urandom_range(0, 49) == 0);
            in_valid_a   = ($urandom_range(0, 2) != 0);
            in_valid_b   = ($urandom_range(0, 2) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            code_word1_a = 7'($urandom);
            code_word2_a = 7'($urandom);
            code_word1_b = 7'($urandom);
            code_word2_b = 7'($urandom);
            tick();
        end
        rst = 1'b0;
        clr_cnt = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
